fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the program counter and drives I_memory, which has one-cycle registered read latency.
- Buffers fetched words in a small prefetch queue and presents one instruction per cycle with its PC+1 value (word addressing).
- Decode stalls via backpressure. Taken branches/jumps from downstream redirect the stream and flush stale words. When no valid word is available, the NOP encoding is presented.

---
 rtl/fetch_prefetch_unit_if.sv | 21 ++
 rtl/fetch_prefetch_unit.sv | 62 ++++++
 tb/tb_fetch_prefetch_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: bundles the I_memory port, the redirect input and the decode-side handshake.
interface fetch_prefetch_unit_if #(parameter int DEPTH = 4);
  logic [15:0] imem_addr;
  logic imem_req;
  logic [15:0] imem_data;
  logic redirect_valid;
  logic [15:0] redirect_pc;
  logic id_ready;
  logic id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic [$clog2(DEPTH):0] q_count;
  modport master (
    output imem_addr, imem_req, id_valid, id_instr, id_pc_next, q_count,
    input imem_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input imem_addr, imem_req, id_valid, id_instr, id_pc_next, q_count,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: owns the PC, fetches from one-cycle I_memory into a prefetch queue, feeds decode.
module fetch_prefetch_unit #(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h7000
) (
  input logic Clk,
  input logic Rst,
  fetch_prefetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  logic [15:0] fetch_pc, inflight_pc, empty_pc;
  logic inflight, push, pop, issue, valid;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic [31:0] q_mem [DEPTH];
  always_comb begin
    valid = count != '0;
    push = inflight & ~bus.redirect_valid;
    pop = valid & bus.id_ready & ~bus.redirect_valid;
    occ = {1'b0, count} + OW'(inflight) + OW'(push) - OW'(pop);
    issue = ~bus.redirect_valid & (occ < OW'(DEPTH));
    empty_pc = (inflight ? inflight_pc : fetch_pc) + 16'd1;
  end
  // Rst gates the request so nothing is issued while reset is held
  assign bus.imem_req = issue & Rst;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid = valid;
  assign bus.id_instr = valid ? q_mem[rd_ptr][31:16] : NOP_INSTR;
  assign bus.id_pc_next = valid ? q_mem[rd_ptr][15:0] : empty_pc;
  assign bus.q_count = count;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_pc <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge Clk)
    if (push) q_mem[wr_ptr] <= {bus.imem_data, inflight_pc + 16'd1};
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed and random fetch traffic checked against a queue-level reference model.
module tb_fetch_prefetch_unit;
  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP = 16'h7000;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mq [$];
  logic [15:0] m_pc, m_inf_pc;
  logic m_inf;
  fetch_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );
  always #5 Clk = ~Clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction
  always @(posedge Clk) bus.imem_data <= bus.imem_req ? memf(bus.imem_addr) : 16'hDEAD;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask
  function automatic void m_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_inf = 1'b0;
    m_inf_pc = RESET_PC;
  endfunction
  function automatic logic m_pop();
    return mq.size() != 0 && bus.id_ready && !bus.redirect_valid;
  endfunction
  function automatic logic m_issue();
    int occ;
    occ = mq.size() + int'(m_inf) + int'(m_inf && !bus.redirect_valid) - int'(m_pop());
    return Rst && !bus.redirect_valid && occ < DEPTH;
  endfunction
  task automatic m_step();
    logic iss, pop, push;
    iss = m_issue();
    pop = m_pop();
    push = m_inf && !bus.redirect_valid;
    if (!Rst) m_reset();
    else if (bus.redirect_valid) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc = bus.redirect_pc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({memf(m_inf_pc), m_inf_pc + 16'd1});
      m_inf = iss;
      if (iss) begin
        m_inf_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end
    end
  endtask
  task automatic cycle();
    logic [15:0] e_instr, e_pcn, p_prev;
    @(negedge Clk);
    e_instr = mq.size() != 0 ? mq[0][31:16] : NOP;
    e_pcn = mq.size() != 0 ? mq[0][15:0] : ((m_inf ? m_inf_pc : m_pc) + 16'd1);
    chk("id_valid", 32'(bus.id_valid), 32'(mq.size() != 0));
    chk("id_instr", 32'(bus.id_instr), 32'(e_instr));
    chk("id_pc_next", 32'(bus.id_pc_next), 32'(e_pcn));
    chk("imem_req", 32'(bus.imem_req), 32'(m_issue()));
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    chk("q_count", 32'(bus.q_count), 32'(mq.size()));
    if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      p_prev = bus.id_pc_next - 16'd1;
      chk("stream", 32'(bus.id_instr), 32'(memf(p_prev)));
    end
    @(posedge Clk);
    m_step();
    #1;
  endtask
  task automatic redirect(input logic [15:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask
  initial begin
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    m_reset();
    repeat (2) cycle();
    chk("rst_pc_next", 32'(bus.id_pc_next), 32'h0001);
    chk("rst_instr", 32'(bus.id_instr), 32'(NOP));
    Rst = 1'b1;
    repeat (10) cycle();
    chk("stall_full", 32'(bus.q_count), 32'd4);
    chk("stall_head", 32'(bus.id_instr), 32'h1000);
    chk("stall_req", 32'(bus.imem_req), 32'd0);
    bus.id_ready = 1'b1;
    repeat (10) cycle();
    redirect(16'h0040);
    chk("redir_bubble", 32'(bus.id_instr), 32'(NOP));
    repeat (2) cycle();
    chk("redir_instr", 32'(bus.id_instr), 32'h1040);
    chk("redir_pcn", 32'(bus.id_pc_next), 32'h0041);
    repeat (4) cycle();
    bus.id_ready = 1'b0;
    repeat (8) cycle();
    chk("full_before_redir", 32'(bus.q_count), 32'd4);
    redirect(16'h0010);
    chk("flush_count", 32'(bus.q_count), 32'd0);
    bus.id_ready = 1'b1;
    repeat (2) cycle();
    chk("flush_first", 32'(bus.id_instr), 32'h1010);
    redirect(16'hFFFE);
    repeat (2) cycle();
    chk("wrap_instr", 32'(bus.id_instr), 32'(memf(16'hFFFE)));
    chk("wrap_pcn", 32'(bus.id_pc_next), 32'h0000FFFF);
    cycle();
    chk("wrap_pcn0", 32'(bus.id_pc_next), 32'h0000);
    cycle();
    chk("wrap_instr2", 32'(bus.id_instr), 32'h1000);
    chk("wrap_pcn1", 32'(bus.id_pc_next), 32'h0001);
    for (int i = 0; i < 300; i++) begin
      bus.id_ready = ($urandom % 4) != 0;
      bus.redirect_valid = ($urandom % 16) == 0;
      bus.redirect_pc = 16'($urandom);
      cycle();
    end
    bus.id_ready = 1'b0;
    redirect(16'h0200);
    for (int i = 0; i < 12 && mq.size() != 3; i++) cycle();
    chk("pre_rst_count", 32'(bus.q_count), 32'd3);
    Rst = 1'b0;
    m_reset();
    #1;
    chk("arst_count", 32'(bus.q_count), 32'd0);
    chk("arst_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_instr", 32'(bus.id_instr), 32'(NOP));
    repeat (2) cycle();
    Rst = 1'b1;
    bus.id_ready = 1'b1;
    repeat (2) cycle();
    chk("refetch_instr", 32'(bus.id_instr), 32'h1000);
    chk("refetch_pcn", 32'(bus.id_pc_next), 32'h0001);
    repeat (6) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
